// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage hazard detection and stall control for a
// 5-stage MIPS pipeline. A shadow pipeline (EX/MEM/WB) tracks in-flight
// destinations so load-use hazards can be caught in ID before forwarding
// is asked to cover something it cannot.
//
// Optional build macro HAZARD_NOFWD_EN: for cores without a forwarding
// unit, any RAW match against EX or MEM stalls until the producer is in WB.
module hazard_stall_ctrl #(
    parameter int CNT_W        = 16,
    parameter int LOAD_USE_CYC = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IFID_RsAddr_i,
    input  logic [4:0]       IFID_RtAddr_i,
    input  logic             ID_RegWrite_i,
    input  logic             ID_MemRead_i,
    input  logic [4:0]       ID_WriteAddr_i,
    input  logic             ID_UsesRt_i,
    input  logic             Branch_Taken_i,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IDEX_Bubble_o,
    output logic             IFID_Flush_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // Wide enough for LOAD_USE_CYC-1 with LOAD_USE_CYC up to 3.
    localparam int SL_W = 2;

    // Shadow pipeline: valid, RegWrite, MemRead, destination address.
    logic             ex_vld_q,  ex_vld_d,  ex_rw_q,  ex_rw_d,  ex_mr_q,  ex_mr_d;
    logic [4:0]       ex_addr_q, ex_addr_d;
    logic             mem_vld_q, mem_vld_d, mem_rw_q, mem_rw_d, mem_mr_q, mem_mr_d;
    logic [4:0]       mem_addr_q, mem_addr_d;
    logic             wb_vld_q,  wb_vld_d,  wb_rw_q,  wb_rw_d,  wb_mr_q,  wb_mr_d;
    logic [4:0]       wb_addr_q, wb_addr_d;

    logic [SL_W-1:0]  stall_left_q, stall_left_d;
    logic             flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;

    logic id_valid;
    logic rs_ex, rt_ex;
    logic hazard;
    logic stall;
    logic flush;

    // The slot right after a taken-branch flush holds a squashed instruction.
    assign id_valid = !flush_pend_q;

    // Source match against EX; rt only counts when the instruction reads it.
    assign rs_ex = ex_vld_q && ex_rw_q && (ex_addr_q == IFID_RsAddr_i) && (IFID_RsAddr_i != 5'd0);
    assign rt_ex = ID_UsesRt_i && ex_vld_q && ex_rw_q && (ex_addr_q == IFID_RtAddr_i)
                   && (IFID_RtAddr_i != 5'd0);

`ifdef HAZARD_NOFWD_EN
    logic rs_mem, rt_mem;
    assign rs_mem = mem_vld_q && mem_rw_q && (mem_addr_q == IFID_RsAddr_i) && (IFID_RsAddr_i != 5'd0);
    assign rt_mem = ID_UsesRt_i && mem_vld_q && mem_rw_q && (mem_addr_q == IFID_RtAddr_i)
                    && (IFID_RtAddr_i != 5'd0);
    // WB needs no check: the register file writes before it is read.
    assign hazard = id_valid && (rs_ex || rt_ex || rs_mem || rt_mem);
    assign stall  = hazard;
`else
    assign hazard = id_valid && ex_mr_q && (rs_ex || rt_ex);
    assign stall  = hazard || (stall_left_q != '0);
`endif

    // A branch is ignored while stalled; it re-resolves once operands are ready.
    assign flush = !stall && Branch_Taken_i && id_valid;

    assign PCWrite_o     = !stall;
    assign IFIDWrite_o   = !stall;
    assign IDEX_Bubble_o = stall;
    assign IFID_Flush_o  = flush;
    assign stall_cnt_o   = stall_cnt_q;

    // Next-state: shadow advance, stall countdown, flush marker, stall counter.
    always_comb begin
        wb_vld_d   = mem_vld_q;
        wb_rw_d    = mem_rw_q;
        wb_mr_d    = mem_mr_q;
        wb_addr_d  = mem_addr_q;
        mem_vld_d  = ex_vld_q;
        mem_rw_d   = ex_rw_q;
        mem_mr_d   = ex_mr_q;
        mem_addr_d = ex_addr_q;
        ex_vld_d   = 1'b0;
        ex_rw_d    = 1'b0;
        ex_mr_d    = 1'b0;
        ex_addr_d  = 5'd0;
        if (!stall && id_valid) begin
            ex_vld_d  = 1'b1;
            ex_rw_d   = ID_RegWrite_i;
            ex_mr_d   = ID_MemRead_i;
            ex_addr_d = ID_WriteAddr_i;
        end

        stall_left_d = '0;
`ifndef HAZARD_NOFWD_EN
        // A hazard seen mid-countdown does not reload the counter.
        if (stall_left_q != '0)
            stall_left_d = stall_left_q - 1'b1;
        else if (hazard)
            stall_left_d = SL_W'(LOAD_USE_CYC - 1);
`endif

        flush_pend_d = flush;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_vld_q     <= 1'b0;
            ex_rw_q      <= 1'b0;
            ex_mr_q      <= 1'b0;
            ex_addr_q    <= 5'd0;
            mem_vld_q    <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_mr_q     <= 1'b0;
            mem_addr_q   <= 5'd0;
            wb_vld_q     <= 1'b0;
            wb_rw_q      <= 1'b0;
            wb_mr_q      <= 1'b0;
            wb_addr_q    <= 5'd0;
            stall_left_q <= '0;
            flush_pend_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            ex_vld_q     <= ex_vld_d;
            ex_rw_q      <= ex_rw_d;
            ex_mr_q      <= ex_mr_d;
            ex_addr_q    <= ex_addr_d;
            mem_vld_q    <= mem_vld_d;
            mem_rw_q     <= mem_rw_d;
            mem_mr_q     <= mem_mr_d;
            mem_addr_q   <= mem_addr_d;
            wb_vld_q     <= wb_vld_d;
            wb_rw_q      <= wb_rw_d;
            wb_mr_q      <= wb_mr_d;
            wb_addr_q    <= wb_addr_d;
            stall_left_q <= stall_left_d;
            flush_pend_q <= flush_pend_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // WB (and some MEM) shadow fields are kept for debug visibility only.
    logic shadow_unused;
    assign shadow_unused = ^{wb_vld_q, wb_rw_q, wb_mr_q, wb_addr_q, mem_mr_q,
                             mem_vld_q, mem_rw_q, mem_addr_q, stall_left_q,
                             SL_W'(LOAD_USE_CYC)};

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a default instance (LOAD_USE_CYC=1,
// CNT_W=16) and a second one (LOAD_USE_CYC=3, CNT_W=2) share the stimulus.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs, rt, wa;
    logic       rw, mr, ut, bt;

    logic        pcw, ifw, bub, fl;
    logic [15:0] cnt;
    logic        pcw3, ifw3, bub3, fl3;
    logic [1:0]  cnt3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.CNT_W(16), .LOAD_USE_CYC(1)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .IFID_RsAddr_i(rs), .IFID_RtAddr_i(rt),
        .ID_RegWrite_i(rw), .ID_MemRead_i(mr), .ID_WriteAddr_i(wa),
        .ID_UsesRt_i(ut), .Branch_Taken_i(bt),
        .PCWrite_o(pcw), .IFIDWrite_o(ifw), .IDEX_Bubble_o(bub),
        .IFID_Flush_o(fl), .stall_cnt_o(cnt)
    );

    hazard_stall_ctrl #(.CNT_W(2), .LOAD_USE_CYC(3)) u_d3 (
        .clk_i(clk), .rst_i(rst),
        .IFID_RsAddr_i(rs), .IFID_RtAddr_i(rt),
        .ID_RegWrite_i(rw), .ID_MemRead_i(mr), .ID_WriteAddr_i(wa),
        .ID_UsesRt_i(ut), .Branch_Taken_i(bt),
        .PCWrite_o(pcw3), .IFIDWrite_o(ifw3), .IDEX_Bubble_o(bub3),
        .IFID_Flush_o(fl3), .stall_cnt_o(cnt3)
    );

    typedef struct {
        logic [4:0] rs, rt, wa;
        logic       rw, mr, ut, bt;
        logic       pcw, bub, fl;
        int         cnt;
    } vec_t;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Apply inputs at the falling edge so they are stable for the next rising edge.
    task automatic drive(input logic [4:0] a_rs, input logic [4:0] a_rt, input logic a_rw,
                         input logic a_mr, input logic [4:0] a_wa, input logic a_ut, input logic a_bt);
        @(negedge clk);
        rs = a_rs; rt = a_rt; rw = a_rw; mr = a_mr; wa = a_wa; ut = a_ut; bt = a_bt;
        #1;
    endtask

    task automatic chk_main(input string tag, input int idx, input logic e_pcw,
                            input logic e_bub, input logic e_fl, input int e_cnt);
        chk({tag, ".PCWrite"}, idx, 32'(pcw), 32'(e_pcw));
        chk({tag, ".IFIDWrite"}, idx, 32'(ifw), 32'(e_pcw));
        chk({tag, ".Bubble"}, idx, 32'(bub), 32'(e_bub));
        chk({tag, ".Flush"}, idx, 32'(fl), 32'(e_fl));
        chk({tag, ".cnt"}, idx, 32'(cnt), 32'(e_cnt));
    endtask

    task automatic chk_d3(input string tag, input int idx, input logic e_pcw,
                          input logic e_bub, input int e_cnt);
        chk({tag, ".PCWrite3"}, idx, 32'(pcw3), 32'(e_pcw));
        chk({tag, ".Bubble3"}, idx, 32'(bub3), 32'(e_bub));
        chk({tag, ".cnt3"}, idx, 32'(cnt3), 32'(e_cnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rs = 0; rt = 0; rw = 0; mr = 0; wa = 0; ut = 0; bt = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    vec_t vecs[13];

    initial begin
        rst = 1'b1;
        rs = 0; rt = 0; rw = 0; mr = 0; wa = 0; ut = 0; bt = 0;

        do_reset();
        chk_main("reset", 0, 1'b1, 1'b0, 1'b0, 0);
        chk_d3("reset", 0, 1'b1, 1'b0, 0);

`ifndef HAZARD_NOFWD_EN
        //          rs  rt  wa  rw mr ut bt  pcw bub fl cnt
        vecs[0]  = '{0,  0,  0,  0, 0, 0, 0, 1, 0, 0, 0}; // nop
        vecs[1]  = '{1,  2,  2,  1, 1, 0, 0, 1, 0, 0, 0}; // lw $2
        vecs[2]  = '{2,  4,  3,  1, 0, 1, 0, 0, 1, 0, 0}; // add $3,$2,$4 stalls
        vecs[3]  = '{2,  4,  3,  1, 0, 1, 0, 1, 0, 0, 1}; // add proceeds
        vecs[4]  = '{1,  0,  0,  1, 1, 0, 0, 1, 0, 0, 1}; // lw $0
        vecs[5]  = '{0,  0,  3,  1, 0, 1, 0, 1, 0, 0, 1}; // add using $0: no stall
        vecs[6]  = '{1,  5,  5,  1, 1, 0, 0, 1, 0, 0, 1}; // lw $5
        vecs[7]  = '{7,  5,  6,  1, 0, 0, 0, 1, 0, 0, 1}; // addi, rt unused: no stall
        vecs[8]  = '{1,  5,  5,  1, 1, 0, 0, 1, 0, 0, 1}; // lw $5
        vecs[9]  = '{9,  5,  0,  0, 0, 1, 1, 0, 1, 0, 1}; // beq taken + load-use: stall, no flush
        vecs[10] = '{9,  5,  0,  0, 0, 1, 1, 1, 0, 1, 2}; // beq re-resolves: flush
        vecs[11] = '{1,  0, 10,  1, 1, 0, 1, 1, 0, 0, 2}; // squashed lw $10, no flush
        vecs[12] = '{10, 0, 11,  1, 0, 1, 0, 1, 0, 0, 2}; // user of squashed lw: no stall

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].rw, vecs[i].mr, vecs[i].wa, vecs[i].ut, vecs[i].bt);
            chk_main("vec", i, vecs[i].pcw, vecs[i].bub, vecs[i].fl, vecs[i].cnt);
        end

        // LOAD_USE_CYC=3: three stall cycles per load-use, 2-bit counter saturates.
        do_reset();
        drive(1, 2, 1, 1, 2, 0, 0); chk_d3("d3", 0, 1'b1, 1'b0, 0); // lw $2
        drive(2, 4, 1, 0, 3, 1, 0); chk_d3("d3", 1, 1'b0, 1'b1, 0);
        drive(2, 4, 1, 0, 3, 1, 0); chk_d3("d3", 2, 1'b0, 1'b1, 1);
        drive(2, 4, 1, 0, 3, 1, 0); chk_d3("d3", 3, 1'b0, 1'b1, 2);
        drive(2, 4, 1, 0, 3, 1, 0); chk_d3("d3", 4, 1'b1, 1'b0, 3);
        drive(1, 2, 1, 1, 2, 0, 0); chk_d3("d3", 5, 1'b1, 1'b0, 3); // lw $2
        drive(2, 4, 1, 0, 3, 1, 0); chk_d3("d3", 6, 1'b0, 1'b1, 3);
        drive(2, 4, 1, 0, 3, 1, 0); chk_d3("d3", 7, 1'b0, 1'b1, 3); // saturated, no wrap
        drive(2, 4, 1, 0, 3, 1, 0); chk_d3("d3", 8, 1'b0, 1'b1, 3);
        drive(2, 4, 1, 0, 3, 1, 0); chk_d3("d3", 9, 1'b1, 1'b0, 3);

        // Reset in the middle of a 3-cycle stall aborts it.
        drive(1, 2, 1, 1, 2, 0, 0); chk_d3("rst_mid", 0, 1'b1, 1'b0, 3);
        drive(2, 4, 1, 0, 3, 1, 0); chk_d3("rst_mid", 1, 1'b0, 1'b1, 3);
        drive(2, 4, 1, 0, 3, 1, 0); rst = 1'b1; chk_d3("rst_mid", 2, 1'b0, 1'b1, 3);
        drive(2, 4, 1, 0, 3, 1, 0); rst = 1'b0; #1;
        chk_d3("rst_mid", 3, 1'b1, 1'b0, 0);
        chk("rst_mid.Flush3", 3, 32'(fl3), 32'd0);
`else
        // No forwarding: ALU result in EX and MEM both stall the consumer.
        drive(1, 3, 1, 0, 2, 1, 0); chk_main("nofwd", 0, 1'b1, 1'b0, 1'b0, 0); // add $2
        drive(2, 1, 1, 0, 4, 1, 0); chk_main("nofwd", 1, 1'b0, 1'b1, 1'b0, 0); // sub $4,$2,$1
        drive(2, 1, 1, 0, 4, 1, 0); rst = 1'b1;
        chk_main("nofwd", 2, 1'b0, 1'b1, 1'b0, 1);
        drive(2, 1, 1, 0, 4, 1, 0); rst = 1'b0; #1;
        chk_main("nofwd", 3, 1'b1, 1'b0, 1'b0, 0);
        // Without the reset the stall lasts exactly two cycles.
        drive(1, 3, 1, 0, 2, 1, 0); chk_main("nofwd2", 0, 1'b1, 1'b0, 1'b0, 0);
        drive(2, 1, 1, 0, 4, 1, 0); chk_main("nofwd2", 1, 1'b0, 1'b1, 1'b0, 0);
        drive(2, 1, 1, 0, 4, 1, 0); chk_main("nofwd2", 2, 1'b0, 1'b1, 1'b0, 1);
        drive(2, 1, 1, 0, 4, 1, 0); chk_main("nofwd2", 3, 1'b1, 1'b0, 1'b0, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- ID-stage hazard detection and stall controller for the 5-stage MIPS pipeline.
- It is the producer-side counterpart of EX-stage forwarding. It tracks in-flight destination registers in a shadow pipeline (EX/MEM/WB) and detects the hazards forwarding cannot cover (load-use).
- It drives PC/IF-ID write enables, the ID/EX bubble, and the IF/ID flush for taken branches.
- It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- CNT_W, 16, width of stall-cycle counter stall_cnt_o.
- LOAD_USE_CYC, 1, stall cycles inserted per load-use hazard (legal 1..3).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- IFID_RsAddr_i  input  5  rs field of instruction in ID.
- IFID_RtAddr_i  input  5  rt field of instruction in ID.
- ID_RegWrite_i  input  1  ID instruction writes a register.
- ID_MemRead_i  input  1  ID instruction is a load.
- ID_WriteAddr_i  input  5  destination register of ID instruction (after RegDst mux).
- ID_UsesRt_i  input  1  ID instruction reads rt as a source (0 for I-type ALU/loads).
- Branch_Taken_i  input  1  branch resolved taken in ID this cycle.
- PCWrite_o  output  1  PC update enable.
- IFIDWrite_o  output  1  IF/ID register write enable.
- IDEX_Bubble_o  output  1  force ID/EX control fields to zero.
- IFID_Flush_o  output  1  zero the IF/ID instruction on next edge.
- stall_cnt_o  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (rst_i=1 at edge):
  - Shadow stages EX/MEM/WB all cleared (valid=0, RegWrite=0, MemRead=0, addr=0).
  - stall_left=0, flush_pend=0, stall_cnt_o=0.
  - Combinational outputs settle to PCWrite_o=1, IFIDWrite_o=1, IDEX_Bubble_o=0, IFID_Flush_o=0.
- ID validity: ID contents are a bubble when flush_pend=1. A bubble contributes no sources and no destination.
- Source match: register r matches stage S iff S.valid && S.RegWrite && S.addr==r && r!=0. Rt is checked only when ID_UsesRt_i=1.
- Load-use hazard: EX.MemRead and EX matches rs or rt.
- stall = (load-use hazard) || (stall_left!=0).
- Outputs while stall=1:
  - PCWrite_o=0, IFIDWrite_o=0, IDEX_Bubble_o=1, IFID_Flush_o=0.
  - Branch_Taken_i is ignored (the branch re-evaluates when operands are ready).
- stall_left (counter) rules:
  - On a new hazard with stall_left==0, load stall_left = LOAD_USE_CYC-1.
  - While stall_left!=0, decrement by 1 per cycle.
  - A new hazard detected while stall_left!=0 does not reload the counter.
- Flush: when stall=0 and Branch_Taken_i=1 and ID is valid, IFID_Flush_o=1 and flush_pend<=1 for exactly the next cycle. flush_pend clears after one cycle.
- Shadow pipeline advance (every cycle):
  - WB<=MEM; MEM<=EX.
  - EX<=ID info when stall=0 and ID valid; otherwise EX<=cleared.
- stall_cnt_o: increments by 1 on every stall=1 cycle. Saturates at all-ones, with no wrap.
- Reset mid-stall: the stall aborts, and outputs return to their reset values the cycle after.

Optional Feature:
- Macro: HAZARD_NOFWD_EN.
- Defined: for pipelines built without the forwarding unit, the hazard condition also includes any match against the EX or MEM stage regardless of MemRead.
  - WB is not checked: the register file writes in the first half and reads in the second.
  - The stall holds until the producer reaches WB.
  - stall_left is unused.
- Undefined: only load-use in EX stalls; ALU-to-ALU hazards are left to forwarding.

Test Plan:
- lw $2 in ID, next add $3,$2,$4 -> exactly 1 stall cycle (PCWrite_o=0, IDEX_Bubble_o=1); stall_cnt_o goes 0->1; add proceeds the next cycle.
- lw $0 followed by add using $0 -> no stall; also lw $5 followed by addi $6,$7,1 with ID_UsesRt_i=0 and rt=5 -> no stall.
- beq taken (Branch_Taken_i=1, no hazard) -> IFID_Flush_o=1 for one cycle; the following ID slot does not enter EX shadow, so a later lw-dependency on it does not stall.
- Branch_Taken_i=1 in the same cycle as a load-use hazard -> IFID_Flush_o=0 and stall=1; the flush asserts on the next cycle if Branch_Taken_i is still 1.
- LOAD_USE_CYC=3 with a load-use pair -> 3 consecutive stall cycles; CNT_W=2 after 5 stall cycles -> stall_cnt_o=3 (saturated).
- HAZARD_NOFWD_EN defined: add $2 then sub $4,$2,$1 -> 2 stall cycles. rst_i asserted during the 2nd stall cycle -> next cycle PCWrite_o=1 and stall_cnt_o=0.
